// File: rtl/dcm_lock_supervisor_pkg.sv
// Shared definitions for the DCM lock supervisor: DCM clock-synthesis
// constants, supervisor state encoding and constant helper functions.
package dcm_lock_supervisor_pkg;

  // DCM_SP clock synthesis settings used by the board clocking wrapper
  localparam int unsigned DCM_CLKFX_MULTIPLY = 2;
  localparam int unsigned DCM_CLKFX_DIVIDE   = 1;
  localparam int unsigned DCM_CLKDV_DIVIDE   = 2;

  // Supervisor state encoding
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DCMRST    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } dcm_state_e;

  // Ceiling log2; clog2(0) and clog2(1) both return 0
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    if (value > 1) begin
      v = value - 1;
      while (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

  // Larger of two constants
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dcm_lock_supervisor_sync2.sv
// Two-flop synchronizer with synchronous active-high reset to zero.
// Generic width so it can also carry the DRAM-domain lock crossing.
module dcm_lock_supervisor_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] meta_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_d;

  // Shift the asynchronous input through the two-stage chain
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  // Synchronizer flops
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/dcm_lock_supervisor.sv
// DCM_SP lock supervisor: pulses DCM RST at start-up and after lock loss,
// retries on lock timeout, latches FAULT after MAX_RETRY timeouts, and
// releases the active-low system reset once lock has been stable.
// Runs on the free-running input clock, never on a DCM output clock.
// Optional: define DCM_LOCK_LOSS_CNT_EN to build the LOSS_CNT register;
// otherwise LOSS_CNT is tied to zero.
module dcm_lock_supervisor
  import dcm_lock_supervisor_pkg::*;
#(
  parameter  int unsigned DCMRST_CYCLES = 4,
  parameter  int unsigned LOCK_TIMEOUT  = 65536,
  parameter  int unsigned STABLE_CYCLES = 1024,
  parameter  int unsigned MAX_RETRY     = 7,
  localparam int unsigned RETRY_W       = clog2(MAX_RETRY + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               LOCKED_IN,
  output logic               DCM_RST,
  output logic               RST_X_OUT,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output logic               FAULT,
  output logic [7:0]         LOSS_CNT
);

  localparam int unsigned CNT_W = clog2(max2(LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]   DCMRST_LAST  = CNT_W'(DCMRST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

  // Reject configurations the DCM or the retry logic cannot honour
  if (DCMRST_CYCLES < 3) begin : g_bad_dcmrst_cycles
    $error("dcm_lock_supervisor: DCMRST_CYCLES must be at least 3");
  end
  if (MAX_RETRY < 1) begin : g_bad_max_retry
    $error("dcm_lock_supervisor: MAX_RETRY must be at least 1");
  end
  if (LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_bad_windows
    $error("dcm_lock_supervisor: LOCK_TIMEOUT and STABLE_CYCLES must be non-zero");
  end

  logic lk_s;

  dcm_state_e         state_q;
  dcm_state_e         state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_d;
  logic               dcm_rst_q;
  logic               dcm_rst_d;
  logic               rst_x_q;
  logic               rst_x_d;
  logic               fault_q;
  logic               fault_d;

  // Bring raw LOCKED into the CLK domain; every decision uses lk_s
  dcm_lock_supervisor_sync2 #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (CLK),
    .rst   (RST),
    .d_in  (LOCKED_IN),
    .q_out (lk_s)
  );

  // Next-state, counter, retry tracking and registered-output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    dcm_rst_d = 1'b0;
    rst_x_d   = 1'b0;
    fault_d   = 1'b0;

    case (state_q)
      ST_DCMRST: begin
        if (cnt_q == DCMRST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Lock beats timeout when both happen on the same cycle
      ST_WAIT_LOCK: begin
        if (lk_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q != RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
          end
          state_d = (retry_d == RETRY_MAX) ? ST_FAULT : ST_DCMRST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A drop here is a glitch: re-wait without a DCM reset or retry count
      ST_STABLE: begin
        if (!lk_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!lk_s) begin
          state_d = ST_DCMRST;
        end
      end

      // Sticky until RST
      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_DCMRST;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // Outputs follow the state being entered so they change on the same edge
    dcm_rst_d = (state_d == ST_DCMRST);
    rst_x_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  // State, counter and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_DCMRST;
      cnt_q     <= '0;
      retry_q   <= '0;
      dcm_rst_q <= 1'b1;
      rst_x_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      dcm_rst_q <= dcm_rst_d;
      rst_x_q   <= rst_x_d;
      fault_q   <= fault_d;
    end
  end

  assign DCM_RST   = dcm_rst_q;
  assign RST_X_OUT = rst_x_q;
  assign RETRY_CNT = retry_q;
  assign FAULT     = fault_q;

`ifdef DCM_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;
  logic [7:0] loss_cnt_d;

  // Count lock losses seen while running, saturating at 255
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if ((state_q == ST_RUN) && !lk_s && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  // Loss counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign LOSS_CNT = loss_cnt_q;
`else
  assign LOSS_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Directed self-checking bench for dcm_lock_supervisor.
// u_dut_def uses default parameters (bring-up timing); u_dut uses short
// windows (LOCK_TIMEOUT=16, STABLE_CYCLES=32) for retry, glitch, loss,
// race and mid-operation reset scenarios. cyc counts edges since the
// most recent reset release; outputs are sampled 1 time unit after each edge.
module tb_dcm_lock_supervisor;

  logic       clk;
  logic       rst_a, lk_a, dcm_rst_a, rst_x_a, fault_a;
  logic [2:0] retry_a;
  logic [7:0] loss_a;
  logic       rst_b, lk_b, dcm_rst_b, rst_x_b, fault_b;
  logic [2:0] retry_b;
  logic [7:0] loss_b;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned cyc;

`ifdef DCM_LOCK_LOSS_CNT_EN
  localparam logic [7:0] LOSS_AFTER_DROP = 8'd1;
`else
  localparam logic [7:0] LOSS_AFTER_DROP = 8'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dcm_lock_supervisor u_dut_def (
    .CLK       (clk),
    .RST       (rst_a),
    .LOCKED_IN (lk_a),
    .DCM_RST   (dcm_rst_a),
    .RST_X_OUT (rst_x_a),
    .RETRY_CNT (retry_a),
    .FAULT     (fault_a),
    .LOSS_CNT  (loss_a)
  );

  dcm_lock_supervisor #(
    .DCMRST_CYCLES (4),
    .LOCK_TIMEOUT  (16),
    .STABLE_CYCLES (32),
    .MAX_RETRY     (7)
  ) u_dut (
    .CLK       (clk),
    .RST       (rst_b),
    .LOCKED_IN (lk_b),
    .DCM_RST   (dcm_rst_b),
    .RST_X_OUT (rst_x_b),
    .RETRY_CNT (retry_b),
    .FAULT     (fault_b),
    .LOSS_CNT  (loss_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_b(input string tag, input logic dr, input logic rx,
                         input logic [2:0] rc, input logic flt, input logic [7:0] lc);
    chk($sformatf("%s_dcm_rst@%0d", tag, cyc), {31'd0, dcm_rst_b}, {31'd0, dr});
    chk($sformatf("%s_rst_x@%0d", tag, cyc), {31'd0, rst_x_b}, {31'd0, rx});
    chk($sformatf("%s_retry@%0d", tag, cyc), {29'd0, retry_b}, {29'd0, rc});
    chk($sformatf("%s_fault@%0d", tag, cyc), {31'd0, fault_b}, {31'd0, flt});
    chk($sformatf("%s_loss@%0d", tag, cyc), {24'd0, loss_b}, {24'd0, lc});
  endtask

  // Hold u_dut in reset for 5 edges with LOCKED low, check, then release
  task automatic reset_b(input string tag);
    rst_b = 1'b1;
    lk_b  = 1'b0;
    repeat (5) tick();
    check_b({tag, "_rst"}, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0);
    rst_b = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d limit_exceeded", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst_a    = 1'b1;
    lk_a     = 1'b0;
    rst_b    = 1'b1;
    lk_b     = 1'b0;

    // Normal bring-up with default parameters: lock at cycle 100, release at 1126
    repeat (5) tick();
    chk("A_rst_dcm_rst", {31'd0, dcm_rst_a}, 32'd1);
    chk("A_rst_rst_x", {31'd0, rst_x_a}, 32'd0);
    chk("A_rst_fault", {31'd0, fault_a}, 32'd0);
    chk("A_rst_retry", {29'd0, retry_a}, 32'd0);
    rst_a = 1'b0;
    cyc   = 0;
    while (cyc < 1126) begin
      tick();
      if (cyc == 99) lk_a = 1'b1;
      if (cyc <= 6) chk($sformatf("A_dcm_rst@%0d", cyc), {31'd0, dcm_rst_a}, {31'd0, (cyc < 4)});
      if (cyc == 1125) chk("A_rst_x_before", {31'd0, rst_x_a}, 32'd0);
    end
    chk("A_rst_x_release", {31'd0, rst_x_a}, 32'd1);
    chk("A_retry", {29'd0, retry_a}, 32'd0);
    chk("A_fault", {31'd0, fault_a}, 32'd0);
    chk("A_loss", {24'd0, loss_a}, 32'd0);

    // Timeout retries: re-pulse every 20 cycles, 7th timeout at 140 -> FAULT
    reset_b("B");
    while (cyc < 160) begin
      tick();
      if (cyc == 145) lk_b = 1'b1;
      if (cyc < 140)
        check_b("B", ((cyc % 20) < 4), 1'b0, 3'(cyc / 20), 1'b0, 8'd0);
      else
        check_b("B", 1'b0, 1'b0, 3'd7, 1'b1, 8'd0);
    end
    // Reset while in FAULT
    rst_b = 1'b1;
    tick();
    check_b("F_fault_rst", 1'b1, 1'b0, 3'd0, 1'b0, 8'd0);

    // Glitch in STABLE at count 20, release at 61; loss in RUN at 70, relock at 80
    reset_b("C");
    lk_b = 1'b1;
    while (cyc < 116) begin
      tick();
      if (cyc == 25) lk_b = 1'b0;
      if (cyc == 26) lk_b = 1'b1;
      if (cyc == 70) lk_b = 1'b0;
      if (cyc == 80) lk_b = 1'b1;
      check_b("C", (cyc < 4) || (cyc >= 73 && cyc <= 76),
              (cyc >= 61 && cyc < 73) || (cyc >= 115), 3'd0, 1'b0,
              (cyc >= 73) ? LOSS_AFTER_DROP : 8'd0);
    end

    // Lock arrives exactly on the timeout cycle: lock wins, no retry
    reset_b("E");
    while (cyc < 54) begin
      tick();
      if (cyc == 17) lk_b = 1'b1;
      check_b("E", (cyc < 4), (cyc >= 52), 3'd0, 1'b0, 8'd0);
    end

    // One timeout, then lock: RETRY_CNT holds 1 through STABLE, clears at RUN
    reset_b("G");
    while (cyc < 66) begin
      tick();
      if (cyc == 30) lk_b = 1'b1;
      check_b("G", (cyc < 4) || (cyc >= 20 && cyc < 24), (cyc >= 65),
              3'((cyc >= 20 && cyc < 65) ? 1 : 0), 1'b0, 8'd0);
    end

    // Reset while in STABLE (entered at 5)
    reset_b("H");
    lk_b = 1'b1;
    while (cyc < 15) tick();
    check_b("H_stable", 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);
    rst_b = 1'b1;
    tick();
    check_b("H_stable_rst", 1'b1, 1'b0, 3'd0, 1'b0, 8'd0);
    rst_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
